// File: rtl/conv3x3_feeder.sv
// Upstream feeder for the 3x3 convolution PE: loads 9 weights and one image frame,
// then streams 9 contiguous (pixel, weight) beats per valid window in raster order.
module conv3x3_feeder #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] wgt_in,
  input  logic              wgt_valid,
  output logic              wgt_ready,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [DATA_W-1:0] pe_in,
  output logic [DATA_W-1:0] pe_filter,
  output logic              feed_valid,
  output logic              window_last,
  output logic              busy,
  output logic              done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = $clog2(NPIX);
  localparam int PCW  = $clog2(NPIX + 1);
  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam logic [RW-1:0]  R_MAX    = RW'(IMG_H - 3);
  localparam logic [CW-1:0]  C_MAX    = CW'(IMG_W - 3);
  localparam logic [3:0]     K_MAX    = 4'd8;
  localparam logic [3:0]     WGT_FULL = 4'd9;
  localparam logic [PCW-1:0] PIX_FULL = PCW'(NPIX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] wgt_mem [9];
  logic [DATA_W-1:0] pix_mem [NPIX];

  logic [3:0]     wgt_cnt;
  logic [PCW-1:0] pix_cnt;
  logic [RW-1:0]  r_q, r_n;
  logic [CW-1:0]  c_q, c_n;
  logic [3:0]     k_q, k_n;
  logic           wgt_full, pix_full, last_beat, emit;
  int             kr, kc;
  logic [AW-1:0]  rd_addr;

  assign wgt_full  = (wgt_cnt == WGT_FULL);
  assign pix_full  = (pix_cnt == PIX_FULL);
  assign last_beat = (r_q == R_MAX) && (c_q == C_MAX) && (k_q == K_MAX);

  assign wgt_ready = (state == S_LOAD) && !wgt_full;
  assign pix_ready = (state == S_LOAD) && !pix_full;
  assign busy      = (state == S_LOAD) || (state == S_FEED);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // r_n/c_n/k_n name the beat to be registered onto the outputs at the next edge;
  // r_q/c_q/k_q name the beat currently on the outputs.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_n = state;
    emit    = 1'b0;
    r_n     = '0;
    c_n     = '0;
    k_n     = '0;
    unique case (state)
      S_IDLE: if (start) state_n = S_LOAD;
      S_LOAD: begin
        if (wgt_full && pix_full) begin
          state_n = S_FEED;
          emit    = 1'b1;
        end
      end
      S_FEED: begin
        if (last_beat) begin
          state_n = S_DONE;
        end else begin
          emit = 1'b1;
          r_n  = r_q;
          c_n  = c_q;
          k_n  = k_q + 4'd1;
          if (k_q == K_MAX) begin
            k_n = '0;
            if (c_q == C_MAX) begin
              c_n = '0;
              r_n = r_q + RW'(1);
            end else begin
              c_n = c_q + CW'(1);
            end
          end
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    kr      = (k_n >= 4'd6) ? 2 : (k_n >= 4'd3) ? 1 : 0;
    kc      = int'(k_n) - 3 * kr;
    rd_addr = AW'((int'(r_n) + kr) * IMG_W + int'(c_n) + kc);
  end

  // NOTE: the storage arrays carry no reset; their contents are always rewritten before use.
  always_ff @(posedge clk) begin
    if (wgt_valid && wgt_ready) wgt_mem[wgt_cnt] <= wgt_in;
    if (pix_valid && pix_ready) pix_mem[AW'(pix_cnt)] <= pix_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wgt_cnt     <= '0;
      pix_cnt     <= '0;
      r_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      pe_in       <= '0;
      pe_filter   <= '0;
      feed_valid  <= 1'b0;
      window_last <= 1'b0;
      done        <= 1'b0;
    end else begin
      feed_valid  <= emit;
      window_last <= emit && (k_n == K_MAX);
      pe_in       <= emit ? pix_mem[rd_addr] : '0;
      pe_filter   <= emit ? wgt_mem[k_n] : '0;
      done        <= (state == S_FEED) && last_beat;

      if (emit) begin
        r_q <= r_n;
        c_q <= c_n;
        k_q <= k_n;
      end

      if (state == S_IDLE && start) begin
        wgt_cnt <= '0;
        pix_cnt <= '0;
        r_q     <= '0;
        c_q     <= '0;
        k_q     <= '0;
      end else begin
        if (wgt_valid && wgt_ready) wgt_cnt <= wgt_cnt + 4'd1;
        if (pix_valid && pix_ready) pix_cnt <= pix_cnt + PCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_feeder.sv
// Scoreboard bench for conv3x3_feeder: a 5x5 instance for the main scenarios and a
// 3x4 instance for the parameter sweep.
module tb_conv3x3_feeder;

  typedef struct packed {
    logic [7:0] pix;
    logic [7:0] wgt;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] wgt_in = '0, pix_in = '0;
  logic       wgt_valid = 1'b0, pix_valid = 1'b0;
  logic       wgt_ready, pix_ready;
  logic [7:0] pe_in, pe_filter;
  logic       feed_valid, window_last, busy, done;

  logic       s_start = 1'b0;
  logic [7:0] s_wgt_in = '0, s_pix_in = '0;
  logic       s_wgt_valid = 1'b0, s_pix_valid = 1'b0;
  logic       s_wgt_ready, s_pix_ready;
  logic [7:0] s_pe_in, s_pe_filter;
  logic       s_feed_valid, s_window_last, s_busy, s_done;

  int         n_checks = 0;
  int         n_fail = 0;
  beat_t      exp_q[$];
  logic [7:0] pix_vals[30];
  logic [7:0] wgt_vals[9];
  int         pix_acc, wgt_acc;
  longint     last_acc_t, first_beat_t;

  always #5 clk = ~clk;

  conv3x3_feeder #(.DATA_W(8), .IMG_W(5), .IMG_H(5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .wgt_in(wgt_in), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pe_in(pe_in), .pe_filter(pe_filter), .feed_valid(feed_valid),
    .window_last(window_last), .busy(busy), .done(done)
  );

  conv3x3_feeder #(.DATA_W(8), .IMG_W(3), .IMG_H(4)) dut_s (
    .clk(clk), .rst(rst), .start(s_start),
    .wgt_in(s_wgt_in), .wgt_valid(s_wgt_valid), .wgt_ready(s_wgt_ready),
    .pix_in(s_pix_in), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
    .pe_in(s_pe_in), .pe_filter(s_pe_filter), .feed_valid(s_feed_valid),
    .window_last(s_window_last), .busy(s_busy), .done(s_done)
  );

  task automatic set_ramp();
    for (int i = 0; i < 30; i++) pix_vals[i] = (i < 25) ? 8'(i) : 8'(100 + i - 25);
    for (int k = 0; k < 9; k++) wgt_vals[k] = 8'(k + 1);
  endtask

  task automatic push_expected_5x5();
    exp_q.delete();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        for (int k = 0; k < 9; k++)
          exp_q.push_back(beat_t'{pix: pix_vals[(r + k / 3) * 5 + c + k % 3],
                                  wgt: wgt_vals[k], last: (k == 8)});
  endtask

  task automatic drive_pix(input int nvals, input bit throttle, input int budget);
    int  i = 0;
    int  cyc = 0;
    bit  drop_checked = 1'b0;
    pix_acc = 0;
    while (cyc < budget && i < nvals) begin
      @(negedge clk);
      cyc++;
      if (pix_acc == 25 && !drop_checked) begin
        drop_checked = 1'b1;
        n_checks++;
        if (pix_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL pix_ready_drop: pix_ready=%b after 25 accepts, required 0", pix_ready);
        end
      end
      pix_valid = throttle ? cyc[0] : 1'b1;
      pix_in    = pix_vals[i];
      if (pix_valid && pix_ready) begin
        i++;
        pix_acc++;
        if ($time > last_acc_t) last_acc_t = $time;
      end
    end
    @(negedge clk);
    if (!drop_checked) begin
      n_checks++;
      if (pix_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL pix_ready_drop: pix_ready=%b after last accept, required 0", pix_ready);
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic drive_wgt(input int delay, input int budget);
    int i = 0;
    int cyc = 0;
    wgt_acc = 0;
    repeat (delay) @(negedge clk);
    while (cyc < budget && i < 9) begin
      @(negedge clk);
      cyc++;
      wgt_valid = 1'b1;
      wgt_in    = wgt_vals[i];
      if (wgt_ready) begin
        i++;
        wgt_acc++;
        if ($time > last_acc_t) last_acc_t = $time;
      end
    end
    @(negedge clk);
    n_checks++;
    if (wgt_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wgt_ready_drop: wgt_ready=%b after last accept, required 0", wgt_ready);
    end
    wgt_valid = 1'b0;
  endtask

  task automatic monitor(input int total, input int start_beat, input int rst_beat);
    int    beats = 0;
    int    cyc = 0;
    bit    fin = 1'b0;
    beat_t e;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (feed_valid) begin
        beats++;
        if (beats == 1) first_beat_t = $time;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_extra: beat %0d appeared, required none beyond %0d", beats, total);
          fin = 1'b1;
        end else begin
          e = exp_q.pop_front();
          if ({pe_in, pe_filter, window_last} !== {e.pix, e.wgt, e.last}) begin
            n_fail++;
            $display("FAIL beat_%0d: pe_in=%0d pe_filter=%0d last=%b, required %0d %0d %b",
                     beats, pe_in, pe_filter, window_last, e.pix, e.wgt, e.last);
          end
          n_checks++;
          if (pe_in >= 8'd100) begin
            n_fail++;
            $display("FAIL extra_word_leak: pe_in=%0d at beat %0d, required < 100", pe_in, beats);
          end
          if (beats == start_beat) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
          end
          if (beats == rst_beat) begin
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            n_checks++;
            if (feed_valid !== 1'b0 || busy !== 1'b0 || pe_in !== 8'd0 || done !== 1'b0) begin
              n_fail++;
              $display("FAIL rst_mid_feed: feed_valid=%b busy=%b pe_in=%0d done=%b, required 0 0 0 0",
                       feed_valid, busy, pe_in, done);
            end
            fin = 1'b1;
          end else if (beats == total) begin
            @(negedge clk);
            n_checks++;
            if (feed_valid !== 1'b0 || done !== 1'b1 || pe_in !== 8'd0 || pe_filter !== 8'd0) begin
              n_fail++;
              $display("FAIL done_pulse: feed_valid=%b done=%b pe_in=%0d pe_filter=%0d, required 0 1 0 0",
                       feed_valid, done, pe_in, pe_filter);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
              n_fail++;
              $display("FAIL done_width: done=%b busy=%b one cycle later, required 0 0", done, busy);
            end
            fin = 1'b1;
          end
        end
      end else if (beats > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL feed_gap: feed_valid=0 after %0d beats, required %0d contiguous", beats, total);
        fin = 1'b1;
      end
    end
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL feed_timeout: %0d beats seen, required %0d", beats, total);
    end
  endtask

  task automatic run_frame(input bit throttle, input int wdelay, input int npix,
                           input bit start_in_load, input int start_beat, input int rst_beat);
    push_expected_5x5();
    last_acc_t = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fork
      drive_pix(npix, throttle, (npix > 25) ? 90 : 500);
      drive_wgt(wdelay, 500);
      monitor(81, start_beat, rst_beat);
      if (start_in_load) begin
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    n_checks++;
    if (pix_acc != 25 || wgt_acc != 9) begin
      n_fail++;
      $display("FAIL accept_count: pixels=%0d weights=%0d, required 25 9", pix_acc, wgt_acc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wgt_valid = 1'b1;
    pix_valid = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({feed_valid, window_last, busy, done, wgt_ready, pix_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: fv=%b wl=%b busy=%b done=%b wr=%b pr=%b, required all 0",
               feed_valid, window_last, busy, done, wgt_ready, pix_ready);
    end
    n_checks++;
    if (pe_in !== 8'd0 || pe_filter !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_data: pe_in=%0d pe_filter=%0d, required 0 0", pe_in, pe_filter);
    end
    start = 1'b0;
    wgt_valid = 1'b0;
    pix_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || pix_ready !== 1'b0 || wgt_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: busy=%b pix_ready=%b wgt_ready=%b, required 0 0 0", busy, pix_ready, wgt_ready);
    end
  endtask

  task automatic test_basic();
    set_ramp();
    run_frame(1'b0, 0, 25, 1'b0, 0, 0);
  endtask

  task automatic test_throttled();
    set_ramp();
    run_frame(1'b1, 20, 25, 1'b0, 0, 0);
    n_checks++;
    if (first_beat_t - last_acc_t != 20) begin
      n_fail++;
      $display("FAIL feed_start_latency: %0d time units after last accept, required 20",
               first_beat_t - last_acc_t);
    end
  endtask

  task automatic test_extra_words();
    set_ramp();
    run_frame(1'b0, 0, 30, 1'b0, 0, 0);
  endtask

  task automatic test_start_outside_idle();
    set_ramp();
    run_frame(1'b0, 0, 25, 1'b1, 30, 0);
  endtask

  task automatic test_reset_mid_feed();
    set_ramp();
    run_frame(1'b0, 0, 25, 1'b0, 0, 40);
    for (int i = 0; i < 30; i++) pix_vals[i] = 8'd7;
    for (int k = 0; k < 9; k++) wgt_vals[k] = 8'd2;
    run_frame(1'b0, 0, 25, 1'b0, 0, 0);
  endtask

  task automatic test_param_sweep();
    logic [7:0] sp[12];
    beat_t      e;
    int         pi = 0, wi = 0, beats = 0, wins = 0, cyc = 0;
    bit         seen_done = 1'b0;
    for (int i = 0; i < 12; i++) sp[i] = 8'(40 + i);
    exp_q.delete();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 9; k++)
        exp_q.push_back(beat_t'{pix: sp[(r + k / 3) * 3 + k % 3], wgt: 8'(11 + k), last: (k == 8)});
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    while (!seen_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (s_feed_valid) begin
        beats++;
        if (s_window_last) wins++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sweep_extra: beat %0d appeared, required only 18", beats);
        end else begin
          e = exp_q.pop_front();
          if ({s_pe_in, s_pe_filter, s_window_last} !== {e.pix, e.wgt, e.last}) begin
            n_fail++;
            $display("FAIL sweep_beat_%0d: pe_in=%0d pe_filter=%0d last=%b, required %0d %0d %b",
                     beats, s_pe_in, s_pe_filter, s_window_last, e.pix, e.wgt, e.last);
          end
        end
      end
      if (s_done) seen_done = 1'b1;
      if (pi < 12) begin
        s_pix_valid = 1'b1;
        s_pix_in    = sp[pi];
        if (s_pix_ready) pi++;
      end else begin
        s_pix_valid = 1'b0;
      end
      if (wi < 9) begin
        s_wgt_valid = 1'b1;
        s_wgt_in    = 8'(11 + wi);
        if (s_wgt_ready) wi++;
      end else begin
        s_wgt_valid = 1'b0;
      end
    end
    n_checks++;
    if (!seen_done || beats != 18 || wins != 2 || pi != 12 || wi != 9) begin
      n_fail++;
      $display("FAIL sweep_totals: done=%b beats=%0d windows=%0d pix=%0d wgt=%0d, required 1 18 2 12 9",
               seen_done, beats, wins, pi, wi);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_throttled();
    test_extra_words();
    test_start_outside_idle();
    test_reset_mid_feed();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
